norm8_pipe: RTL and testbench

NORM8_PIPE -- requirements
Module: norm8_pipe

---
 rtl/norm8_pipe.sv | 112 +++++++++++
 tb/tb_norm8_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/norm8_pipe.sv
// rtl/norm8_pipe.sv - two-stage 8-bit normalizer (leading-zero shift + exponent) with result counter
// lzd8b is the combinational leading-zero front end; norm8_pipe stalls the whole pipe on backpressure.

module lzd8b (
  input  logic [7:0] i8,
  output logic [3:0] z8
);
  always_comb begin
    z8 = 4'd8;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < 8; i++) begin
      if (i8[i]) z8 = 4'(7 - i);
    end
  end
endmodule

module norm8_pipe #(
  parameter int EXP_BASE = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_mant,
  output logic [3:0] out_exp,
  output logic       out_zero,
  output logic [7:0] out_cnt
);
  logic       adv;
  logic [3:0] z8;

  logic       s1_valid;
  logic [7:0] s1_data;
  logic [3:0] s1_z;

  logic       s2_valid;
  logic [7:0] s2_mant;
  logic [3:0] s2_exp;
  logic       s2_zero;

  logic [7:0] mant_next;
  logic [3:0] exp_next;
  logic       zero_next;
  logic [7:0] cnt;

  lzd8b u_lzd (
    .i8 (in_data),
    .z8 (z8)
  );

  assign adv      = !s2_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= 8'h00;
      s1_z     <= 4'h0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_z    <= z8;
      end
    end
  end

  always_comb begin
    mant_next = 8'h00;
    exp_next  = 4'h0;
    zero_next = 1'b1;
    if (!s1_z[3]) begin
      mant_next = s1_data << s1_z;
      exp_next  = 4'(EXP_BASE) - s1_z;
      zero_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mant  <= 8'h00;
      s2_exp   <= 4'h0;
      s2_zero  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mant <= mant_next;
        s2_exp  <= exp_next;
        s2_zero <= zero_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'h00;
    end else if (s2_valid && out_ready) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Stage data is stale when invalid, so mask it to keep idle outputs at zero.
  assign out_valid = s2_valid;
  assign out_mant  = {8{s2_valid}} & s2_mant;
  assign out_exp   = {4{s2_valid}} & s2_exp;
  assign out_zero  = s2_valid & s2_zero;
  assign out_cnt   = cnt;
endmodule

// File: tb/tb_norm8_pipe.sv
// tb/tb_norm8_pipe.sv - scoreboard bench for norm8_pipe against an arithmetic normalization model
module tb_norm8_pipe;
  localparam int EXP_BASE = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [3:0] out_exp;
  logic       out_zero;
  logic [7:0] out_cnt;

  int errors = 0;
  int checks = 0;
  logic [12:0] sb[$];
  int exp_cnt = 0;
  int last_wait;
  bit done;

  norm8_pipe #(.EXP_BASE(EXP_BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Normalize by doubling until the top bit is set; exponent falls by one per doubling.
  function automatic logic [12:0] model(input int x);
    int m;
    int z;
    if (x == 0) return {8'h00, 4'h0, 1'b1};
    m = x;
    z = 0;
    while (m < 128) begin
      m = m * 2;
      z++;
    end
    return {8'(m), 4'((EXP_BASE - z) & 15), 1'b0};
  endfunction

  task automatic send(input logic [7:0] x);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = x;
    last_wait = 0;
    while (!acc && last_wait < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb.push_back(model(int'(x)));
      end
      @(posedge clk);
      #1;
      if (!acc) last_wait++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
    idle(1);
  endtask

  // Monitor: pops the scoreboard on every output transfer and tracks the consumed count.
  initial begin : monitor
    logic [12:0] e;
    bit held = 0;
    logic [12:0] hv;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt = 0;
        held = 0;
      end else begin
        chk("out_cnt", int'(out_cnt), exp_cnt);
        if (held) chk("hold_outputs", int'({out_valid, out_mant, out_exp, out_zero}), int'({1'b1, hv}));
        if (!out_valid) begin
          chk("idle_outputs", int'({out_mant, out_exp, out_zero}), 0);
        end else if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", int'({out_mant, out_exp, out_zero}), -1);
          end else begin
            e = sb.pop_front();
            chk("mant", int'(out_mant), int'(e[12:5]));
            chk("exp", int'(out_exp), int'(e[4:1]));
            chk("zero", int'(out_zero), int'(e[0]));
            if (!out_zero) chk("mant_msb", int'(out_mant[7]), 1);
          end
          exp_cnt = (exp_cnt + 1) % 256;
        end
        held = out_valid && !out_ready;
        hv = {out_mant, out_exp, out_zero};
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_outputs", int'({out_mant, out_exp, out_zero}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'b0001_0110);
    chk("first_accept_wait", last_wait, 0);
    chk("latency_not_early", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_mant", int'(out_mant), 8'hb0);
    chk("latency_exp", int'(out_exp), 4);
    idle(2);

    send(8'h80);
    send(8'h01);
    send(8'h00);
    drain();
    chk("cnt_after_seq", int'(out_cnt), 4);

    done = 0;
    fork
      begin
        send(8'h40); send(8'h07); send(8'hff); send(8'h02);
      end
      begin
        out_ready = 1'b0;
        repeat (4) begin
          @(posedge clk);
          #1;
        end
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(8'($urandom));
          if ($urandom_range(3) == 0) idle($urandom_range(2));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    out_ready = 1'b0;
    send(8'h33);
    send(8'h0c);
    chk("pre_reset_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_cnt", int'(out_cnt), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(5);

    for (int v = 0; v < 256; v++) send(8'(v));
    send(8'h5a);
    drain();
    chk("cnt_wrap", int'(out_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
